// File: rtl/k_imem_pkg.sv
// Shared types and constants for the instruction memory.
// Optional feature macro: K_IMEM_PARITY_EN (per-word even parity + parity_err port).
package k_imem_pkg;

    typedef logic [31:0] word_t;

    // RISC-V "addi x0, x0, 0": the safe filler for empty or out-of-range words
    localparam word_t K_IMEM_NOP   = 32'h0000_0013;
    // Boot stub: addi x1,x0,5 ; addi x2,x0,10 ; add x3,x1,x2 ; ecall
    localparam word_t K_IMEM_INIT0 = 32'h0050_0093;
    localparam word_t K_IMEM_INIT1 = 32'h00A0_0113;
    localparam word_t K_IMEM_INIT2 = 32'h0020_81B3;
    localparam word_t K_IMEM_INIT3 = 32'h0000_0073;

endpackage

// File: rtl/k_imem_parity.sv
// Even-parity generation for writes and reset contents, and parity check on reads.
// Only instantiated when K_IMEM_PARITY_EN is defined.
module k_imem_parity
    import k_imem_pkg::*;
(
    input  word_t       wdata,
    input  word_t       rdata,
    input  logic        rparity,
    input  logic        addr_err,
    output logic        wparity,
    output logic [4:0]  rst_parity,
    output logic        parity_err
);

    // Even parity: stored bit makes the XOR of data plus parity bit zero
    function automatic logic even_parity(input word_t w);
        return ^w;
    endfunction

    // Parity bits for the written word and for every word that reset can load
    always_comb begin
        wparity    = even_parity(wdata);
        rst_parity = {even_parity(K_IMEM_NOP),
                      even_parity(K_IMEM_INIT3),
                      even_parity(K_IMEM_INIT2),
                      even_parity(K_IMEM_INIT1),
                      even_parity(K_IMEM_INIT0)};
    end

    // Flag a read word whose stored parity does not match; out-of-range reads never flag
    always_comb begin
        parity_err = 1'b0;
        if (addr_err) begin
            parity_err = 1'b0;
        end else begin
            parity_err = even_parity(rdata) ^ rparity;
        end
    end

endmodule

// File: rtl/k_instruction_memory.sv
// Instruction memory: combinational word-addressed read port, clocked program-load
// write port, range checking on both ports, asynchronous reset to a boot stub.
// Optional feature macro: K_IMEM_PARITY_EN adds per-word parity and a parity_err output.
module k_instruction_memory
    import k_imem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    output logic [31:0] instruction,
    output logic        addr_err,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    output logic        wr_err
`ifdef K_IMEM_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    word_t mem_r [DEPTH];
    logic  wr_err_r;
    logic  addr_err_s;
    logic  waddr_oob_s;
    word_t rword_s;
    word_t instr_s;

    // Full 32-bit range checks so upper address bits never alias into the array
    always_comb begin
        addr_err_s  = (address >= 32'(DEPTH));
        waddr_oob_s = (waddr >= 32'(DEPTH));
        rword_s     = mem_r[address[AW-1:0]];
    end

    // Read mux: out-of-range reads return a NOP instead of an aliased word
    always_comb begin
        instr_s = K_IMEM_NOP;
        if (addr_err_s) begin
            instr_s = K_IMEM_NOP;
        end else begin
            instr_s = rword_s;
        end
    end

`ifdef K_IMEM_PARITY_EN
    logic [DEPTH-1:0] par_bits_r;
    logic             wpar_s;
    logic [4:0]       rst_par_s;

    k_imem_parity u_parity (
        .wdata      (wdata),
        .rdata      (rword_s),
        .rparity    (par_bits_r[address[AW-1:0]]),
        .addr_err   (addr_err_s),
        .wparity    (wpar_s),
        .rst_parity (rst_par_s),
        .parity_err (parity_err)
    );

    // Parity storage follows the data array: reset load and in-range writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_bits_r[i] <= (i < 4) ? rst_par_s[i] : rst_par_s[4];
            end
        end else if (we && !waddr_oob_s) begin
            par_bits_r[waddr[AW-1:0]] <= wpar_s;
        end else begin
            par_bits_r <= par_bits_r;
        end
    end
`endif

    // Storage array: boot stub on reset, otherwise load in-range words when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                case (i)
                    32'sd0:  mem_r[i] <= K_IMEM_INIT0;
                    32'sd1:  mem_r[i] <= K_IMEM_INIT1;
                    32'sd2:  mem_r[i] <= K_IMEM_INIT2;
                    32'sd3:  mem_r[i] <= K_IMEM_INIT3;
                    default: mem_r[i] <= K_IMEM_NOP;
                endcase
            end
        end else if (we && !waddr_oob_s) begin
            mem_r[waddr[AW-1:0]] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Sticky write-range error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else if (we && waddr_oob_s) begin
            wr_err_r <= 1'b1;
        end else begin
            wr_err_r <= wr_err_r;
        end
    end

    assign instruction = instr_s;
    assign addr_err    = addr_err_s;
    assign wr_err      = wr_err_r;

endmodule

// File: tb/tb_k_instruction_memory.sv
// Self-checking bench for k_instruction_memory (default DEPTH=64).
// Parity checks are included when K_IMEM_PARITY_EN is defined.
module tb_k_instruction_memory;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        addr_err;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wr_err;
`ifdef K_IMEM_PARITY_EN
    logic        parity_err;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_err;
    } rd_vec_t;

    rd_vec_t vecs [10];

    k_instruction_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .instruction (instruction),
        .addr_err    (addr_err),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .wr_err      (wr_err)
`ifdef K_IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_en  = 1'b1;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 32'd0;
        wdata   = 32'd0;
        address = 32'd0;

        vecs[0] = '{32'd0,          32'h0050_0093, 1'b0};
        vecs[1] = '{32'd1,          32'h00A0_0113, 1'b0};
        vecs[2] = '{32'd2,          32'h0020_81B3, 1'b0};
        vecs[3] = '{32'd3,          32'h0000_0073, 1'b0};
        vecs[4] = '{32'd10,         32'h0000_0013, 1'b0};
        vecs[5] = '{32'd63,         32'h0000_0013, 1'b0};
        vecs[6] = '{32'd64,         32'h0000_0013, 1'b1};
        vecs[7] = '{32'd65,         32'h0000_0013, 1'b1};
        vecs[8] = '{32'h0000_0100,  32'h0000_0013, 1'b1};
        vecs[9] = '{32'hFFFF_FFFF,  32'h0000_0013, 1'b1};

        // reset contents visible while reset is held
        #12;
        check("rst_read_addr0", instruction, 32'h0050_0093);
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // combinational reads with 5-unit steps
        for (int i = 0; i < 10; i++) begin
            address = vecs[i].addr;
            #5;
            check($sformatf("read_instr[%0d]", i), instruction, vecs[i].exp_instr);
            check($sformatf("read_err[%0d]", i), {31'd0, addr_err}, {31'd0, vecs[i].exp_err});
        end

        // write with matching read address: old word before edge, new after
        @(negedge clk);
        address = 32'd5;
        we      = 1'b1;
        waddr   = 32'd5;
        wdata   = 32'hDEAD_BEEF;
        #1;
        check("wr_before_edge", instruction, 32'h0000_0013);
        @(posedge clk);
        #1;
        check("wr_after_edge", instruction, 32'hDEAD_BEEF);
        check("wr_ok_no_err", {31'd0, wr_err}, 32'd0);

        // out-of-range writes: one far, one that would alias onto word 5
        @(negedge clk);
        waddr = 32'd100;
        wdata = 32'h1234_5678;
        @(negedge clk);
        waddr = 32'd69;
        @(negedge clk);
        we    = 1'b0;
        check("oob_wr_err", {31'd0, wr_err}, 32'd1);
        check("oob_word5", instruction, 32'hDEAD_BEEF);
        address = 32'd36;
        #1;
        check("oob_word36", instruction, 32'h0000_0013);

        // we=0: data/address changes must not write; wr_err sticky
        waddr = 32'd36;
        wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        check("no_we_word36", instruction, 32'h0000_0013);
        check("wr_err_sticky", {31'd0, wr_err}, 32'd1);

        // asynchronous reset with clock stopped
        clk_en = 1'b0;
        #20;
        address = 32'd5;
        rst_n   = 1'b0;
        #1;
        check("async_rst_wr_err", {31'd0, wr_err}, 32'd0);
        check("async_rst_word5", instruction, 32'h0000_0013);

        // writes ignored while reset is held
        we     = 1'b1;
        waddr  = 32'd1;
        wdata  = 32'hAAAA_5555;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        address = 32'd1;
        #1;
        check("rst_write_ignored", instruction, 32'h00A0_0113);
        we    = 1'b0;
        rst_n = 1'b1;

        // mid-operation reset discards loaded words
        @(negedge clk);
        we      = 1'b1;
        waddr   = 32'd0;
        wdata   = 32'h1111_1111;
        address = 32'd0;
        @(negedge clk);
        we = 1'b0;
        check("load_word0", instruction, 32'h1111_1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_word0", instruction, 32'h0050_0093);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef K_IMEM_PARITY_EN
        address = 32'd2;
        #1;
        check("par_clean", {31'd0, parity_err}, 32'd0);
        force dut.par_bits_r[2] = ~(^32'h0020_81B3);
        #1;
        check("par_err_word2", {31'd0, parity_err}, 32'd1);
        address = 32'd3;
        #1;
        check("par_ok_word3", {31'd0, parity_err}, 32'd0);
        address = 32'd64;
        #1;
        check("par_oob_masked", {31'd0, parity_err}, 32'd0);
        release dut.par_bits_r[2];
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/k_instruction_memory.md
K_INSTRUCTION_MEMORY -- requirements
Module: k_instruction_memory

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit instruction words (power of two, 4..256).
REQ-002 Parameter AW, default $clog2(DEPTH): number of address bits that index the array.
REQ-003 Port clk, input, 1: single clock; all writes are sampled on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port address, input, 32: word address for the read port (address N selects word N, not byte N).
REQ-006 Port instruction, output, 32: instruction word read from address.
REQ-007 Port addr_err, output, 1: high when address >= DEPTH.
REQ-008 Port we, input, 1: program-load write enable.
REQ-009 Port waddr, input, 32: word address for the write port.
REQ-010 Port wdata, input, 32: write data.
REQ-011 Port wr_err, output, 1: sticky flag, set by a write to an address >= DEPTH.

Function
REQ-012 Read SHALL be combinational, zero latency: instruction = mem[address[AW-1:0]] whenever address < DEPTH.
REQ-013 When address >= DEPTH, instruction SHALL be K_IMEM_NOP (32'h0000_0013) and addr_err SHALL be 1; otherwise addr_err SHALL be 0.
REQ-014 A write SHALL occur on the rising clk edge when we=1 and waddr < DEPTH; it updates mem[waddr].
REQ-015 A write with waddr >= DEPTH SHALL leave the memory unchanged and set wr_err, which stays set until reset.
REQ-016 When the read and write addresses match, instruction SHALL show the old word until the clock edge and the new word immediately after it; there is no bypass.
REQ-017 When we=0 the memory contents SHALL never change except through reset.
REQ-018 Address bits above AW SHALL only be used for the range check; there is no wrap-around aliasing.

Reset
REQ-019 While rst_n=0, asynchronously: mem[0..3] SHALL load K_IMEM_INIT0..3, mem[4..DEPTH-1] SHALL load K_IMEM_NOP, and wr_err SHALL be 0.
REQ-020 While rst_n=0, instruction SHALL reflect the reset contents combinationally, so address 0 gives K_IMEM_INIT0.
REQ-021 Writes SHALL be ignored while rst_n=0.
REQ-022 Reset asserted mid-operation SHALL discard all previously loaded words.

Configuration
REQ-023 Macro K_IMEM_PARITY_EN defined: each word SHALL store an extra even-parity bit computed on write and on reset load, and an output parity_err SHALL be high when the word being read fails its parity check (always 0 when addr_err=1).
REQ-024 Macro K_IMEM_PARITY_EN undefined: there is no parity storage and no parity_err port; behaviour is otherwise identical.

Structure
REQ-025 Package k_imem_pkg SHALL hold K_IMEM_NOP=32'h0000_0013, K_IMEM_INIT0=32'h0050_0093, K_IMEM_INIT1=32'h00A0_0113, K_IMEM_INIT2=32'h0020_81B3, K_IMEM_INIT3=32'h0000_0073, and a word typedef.
REQ-026 Parity generation and checking SHALL live in one sub-module, k_imem_parity, instantiated only when K_IMEM_PARITY_EN is defined.

Verification
REQ-027 Apply reset, release it, then drive address 0,1,2,3 with 5-time-unit steps and no clock edges -> instruction = 00500093, 00A00113, 002081B3, 00000073.
REQ-028 Drive address=10 after reset -> instruction=00000013, addr_err=0; drive address=64 -> instruction=00000013, addr_err=1.
REQ-029 Write we=1, waddr=5, wdata=DEADBEEF while address=5 -> instruction=00000013 before the edge, DEADBEEF after it.
REQ-030 Write waddr=100, wdata=12345678 -> wr_err=1 and no word changes; assert rst_n=0 with no clock running -> wr_err=0 and mem[5] returns to 00000013 at once.
REQ-031 Assert rst_n=0 while we=1 on an in-range address -> the write is ignored and the reset contents remain.
REQ-032 With K_IMEM_PARITY_EN, force an error by flipping one stored bit of word 2 via a hierarchical force and read address 2 -> parity_err=1; reads of other words -> parity_err=0.
